// File: rtl/risc_trace_pkg.sv
// risc_trace_pkg: shared state encoding, capture-mode constants and trace record helpers.
package risc_trace_pkg;
  typedef enum logic [1:0] {IDLE, RUN, HALT} trace_state_e;
  localparam logic MODE_ALL = 1'b0;
  localparam logic MODE_CHANGE = 1'b1;
  localparam int REC_MAX = 96;
  // Fields are at most 32 bits and are passed zero-extended; callers truncate to their record width.
  function automatic logic [REC_MAX-1:0] pack_rec(input logic [31:0] cyc, input logic [31:0] ir,
                                                  input logic [31:0] pc, input int ir_w, input int pc_w);
    return (REC_MAX'(cyc) << (ir_w + pc_w)) | (REC_MAX'(ir) << pc_w) | REC_MAX'(pc);
  endfunction
  function automatic logic [31:0] rec_field(input logic [REC_MAX-1:0] rec, input int lsb, input int w);
    logic [32:0] m;
    m = (33'd1 << w) - 33'd1;
    return 32'(rec >> lsb) & m[31:0];
  endfunction
endpackage

// File: rtl/risc_trace_fifo.sv
// risc_trace_fifo: synchronous FIFO with ready/valid head, full flag and a strobe for pushes lost to a full queue.
module risc_trace_fifo #(
  parameter int W = 48,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         dropped
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic pop, wr;
  always_comb begin
    valid = wp != rp;
    full = (wp ^ rp) == {1'b1, {AW{1'b0}}};
    pop = valid && ready;
    wr = push && (!full || pop);
    dropped = push && full && !pop;
    dout = mem[rp[AW-1:0]];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wp <= '0;
      rp <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr) begin
        mem[wp[AW-1:0]] <= din;
        wp <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
    end
endmodule

// File: rtl/risc_trace_unit.sv
// risc_trace_unit: cycle counter and {cycle, IR, PC} trace capture for the 16-bit RISC pipeline.
module risc_trace_unit
  import risc_trace_pkg::*;
#(
  parameter int CC_W = 16,
  parameter int IR_W = 16,
  parameter int PC_W = 16,
  parameter int DEPTH = 8,
  parameter int DROP_W = 8
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     CLEAR,
  input  logic                     START,
  input  logic                     MODE,
  input  logic                     HOLT,
  input  logic [IR_W-1:0]          IR,
  input  logic [PC_W-1:0]          PC,
  output logic [CC_W-1:0]          CYCLE_COUNT,
  output logic                     HALTED,
  output logic                     TR_VALID,
  input  logic                     TR_READY,
  output logic [CC_W+IR_W+PC_W-1:0] TR_DATA,
  output logic                     TR_FULL,
  output logic [DROP_W-1:0]        DROP_COUNT
);
  localparam int REC_W = CC_W + IR_W + PC_W;
  trace_state_e state;
  logic [IR_W-1:0] last_ir;
  logic [PC_W-1:0] last_pc;
  logic last_valid, push, dropped;
  logic [REC_W-1:0] rec;
  // The halt-transition cycle always records, marking where the program stopped.
  always_comb begin
    rec = REC_W'(pack_rec(32'(CYCLE_COUNT), 32'(IR), 32'(PC), IR_W, PC_W));
    push = !CLEAR && state == RUN &&
           (HOLT || MODE == MODE_ALL || !last_valid || IR != last_ir || PC != last_pc);
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state <= IDLE;
      CYCLE_COUNT <= '0;
      HALTED <= 1'b0;
      DROP_COUNT <= '0;
      last_ir <= '0;
      last_pc <= '0;
      last_valid <= 1'b0;
    end else if (CLEAR) begin
      state <= IDLE;
      CYCLE_COUNT <= '0;
      HALTED <= 1'b0;
      DROP_COUNT <= '0;
      last_valid <= 1'b0;
    end else begin
      state <= state == RUN ? (HOLT ? HALT : RUN) : (START ? RUN : state);
      HALTED <= (state == RUN && HOLT) || (state == HALT && !START);
      if (state == RUN && !HOLT) CYCLE_COUNT <= CYCLE_COUNT + 1'b1;
      if (dropped && DROP_COUNT != '1) DROP_COUNT <= DROP_COUNT + 1'b1;
      if (push) begin
        last_ir <= IR;
        last_pc <= PC;
        last_valid <= 1'b1;
      end else if (state != RUN && START) last_valid <= 1'b0;
    end
  risc_trace_fifo #(.W(REC_W), .DEPTH(DEPTH)) u_fifo (
    .clk(CLK),
    .rst_n(RST_N),
    .clear(CLEAR),
    .push(push),
    .din(rec),
    .ready(TR_READY),
    .valid(TR_VALID),
    .dout(TR_DATA),
    .full(TR_FULL),
    .dropped(dropped)
  );
endmodule

// File: tb/tb_risc_trace_unit.sv
// tb_risc_trace_unit: directed checks of counting, capture modes, overflow, clear priority and wrap.
module tb_risc_trace_unit;
  import risc_trace_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, start = 1'b0, mode = 1'b0, holt = 1'b0, tr_ready = 1'b0;
  logic [15:0] ir = '0, pc = '0, cc;
  logic halted, tr_valid, tr_full;
  logic [47:0] tr_data;
  logic [7:0] drop;
  logic clear2 = 1'b0, start2 = 1'b0, holt2 = 1'b0;
  logic [7:0] cc2, drop2;
  logic halted2, tr_valid2, tr_full2;
  logic [39:0] tr_data2;
  logic [47:0] got [$];
  logic [15:0] pcs [5] = '{16'd0, 16'd0, 16'd1, 16'd1, 16'd2};
  logic [31:0] exp_cyc [12] = '{0, 1, 2, 3, 4, 5, 6, 7, 20, 21, 22, 23};
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  risc_trace_unit dut (
    .CLK(clk), .RST_N(rst_n), .CLEAR(clear), .START(start), .MODE(mode), .HOLT(holt),
    .IR(ir), .PC(pc), .CYCLE_COUNT(cc), .HALTED(halted), .TR_VALID(tr_valid),
    .TR_READY(tr_ready), .TR_DATA(tr_data), .TR_FULL(tr_full), .DROP_COUNT(drop)
  );
  risc_trace_unit #(.CC_W(8)) dut8 (
    .CLK(clk), .RST_N(rst_n), .CLEAR(clear2), .START(start2), .MODE(mode), .HOLT(holt2),
    .IR(ir), .PC(pc), .CYCLE_COUNT(cc2), .HALTED(halted2), .TR_VALID(tr_valid2),
    .TR_READY(tr_ready), .TR_DATA(tr_data2), .TR_FULL(tr_full2), .DROP_COUNT(drop2)
  );
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // Records a pop whenever the handshake holds just before the coming edge.
  task automatic step();
    if (tr_valid && tr_ready) got.push_back(tr_data);
    @(posedge clk);
    #1;
  endtask
  task automatic check_idle_zero(input string tag);
    check({tag, "_cc"}, 64'(cc), 0);
    check({tag, "_halted"}, 64'(halted), 0);
    check({tag, "_valid"}, 64'(tr_valid), 0);
    check({tag, "_data"}, 64'(tr_data), 0);
    check({tag, "_full"}, 64'(tr_full), 0);
    check({tag, "_drop"}, 64'(drop), 0);
  endtask
  initial begin
    #2;
    check_idle_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    // every-cycle capture, halt after 6 counted cycles
    tr_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    got.delete();
    for (int i = 0; i < 6; i++) begin
      ir = 16'hA000 + 16'(i);
      pc = 16'(i);
      step();
    end
    ir = 16'hBEEF;
    pc = 16'h0040;
    holt = 1'b1;
    step();
    holt = 1'b0;
    check("all_cc", 64'(cc), 6);
    check("all_halted", 64'(halted), 1);
    repeat (4) step();
    check("all_count", 64'(got.size()), 7);
    for (int i = 0; i < 6 && i < got.size(); i++)
      check("all_rec", 64'(got[i]), 64'({16'(i), 16'hA000 + 16'(i), 16'(i)}));
    if (got.size() > 6) check("all_halt_rec", 64'(got[6]), 64'({16'd6, 16'hBEEF, 16'h0040}));
    // change-only capture
    clear = 1'b1;
    step();
    clear = 1'b0;
    got.delete();
    mode = MODE_CHANGE;
    ir = 16'h1234;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pc = pcs[i];
      step();
    end
    holt = 1'b1;
    step();
    holt = 1'b0;
    check("chg_cc", 64'(cc), 5);
    repeat (3) step();
    check("chg_count", 64'(got.size()), 4);
    if (got.size() == 4) begin
      check("chg_rec0", 64'(got[0]), 64'({16'd0, 16'h1234, 16'd0}));
      check("chg_rec1", 64'(got[1]), 64'({16'd2, 16'h1234, 16'd1}));
      check("chg_rec2", 64'(got[2]), 64'({16'd4, 16'h1234, 16'd2}));
      check("chg_halt", 64'(got[3]), 64'({16'd5, 16'h1234, 16'd2}));
    end
    // overflow with the consumer stalled
    clear = 1'b1;
    step();
    clear = 1'b0;
    got.delete();
    mode = MODE_ALL;
    tr_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ir = 16'hC000 + 16'(i);
      pc = 16'h0100 + 16'(i);
      step();
    end
    check("ovf_full", 64'(tr_full), 1);
    check("ovf_drop", 64'(drop), 12);
    check("ovf_cc", 64'(cc), 20);
    check("ovf_head", 64'(tr_data), 64'({16'd0, 16'hC000, 16'h0100}));
    // full with simultaneous push and pop
    tr_ready = 1'b1;
    for (int i = 20; i < 23; i++) begin
      ir = 16'hC000 + 16'(i);
      pc = 16'h0100 + 16'(i);
      step();
      check("pp_full", 64'(tr_full), 1);
      check("pp_drop", 64'(drop), 12);
    end
    holt = 1'b1;
    step();
    holt = 1'b0;
    check("pp_halt_drop", 64'(drop), 12);
    check("pp_halt_cc", 64'(cc), 23);
    repeat (10) step();
    check("drain_count", 64'(got.size()), 12);
    for (int i = 0; i < 12 && i < got.size(); i++)
      check("drain_cycle", 64'(rec_field(REC_MAX'(got[i]), 32, 16)), 64'(exp_cyc[i]));
    check("drain_valid", 64'(tr_valid), 0);
    check("drain_full", 64'(tr_full), 0);
    // clear beats start and halt in the same cycle
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (2) step();
    check("resume_cc", 64'(cc), 25);
    clear = 1'b1;
    start = 1'b1;
    holt = 1'b1;
    step();
    clear = 1'b0;
    start = 1'b0;
    holt = 1'b0;
    check_idle_zero("clr");
    step();
    check("clr_idle_cc", 64'(cc), 0);
    check("clr_idle_valid", 64'(tr_valid), 0);
    // asynchronous reset in the middle of a run
    tr_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    check("pre_rst_cc", 64'(cc), 5);
    check("pre_rst_valid", 64'(tr_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_zero("async_rst");
    rst_n = 1'b1;
    step();
    // 8-bit counter wrap and drop saturation
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    repeat (255) step();
    check("wrap_255", 64'(cc2), 255);
    check("wrap_drop", 64'(drop2), 247);
    step();
    check("wrap_0", 64'(cc2), 0);
    repeat (10) step();
    check("drop_sat", 64'(drop2), 255);
    check("wrap_halted", 64'(halted2), 0);
    clear2 = 1'b1;
    start2 = 1'b1;
    holt2 = 1'b1;
    step();
    clear2 = 1'b0;
    start2 = 1'b0;
    holt2 = 1'b0;
    check("clr8_cc", 64'(cc2), 0);
    check("clr8_drop", 64'(drop2), 0);
    check("clr8_full", 64'(tr_full2), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/risc_trace_unit.md
Name: risc_trace_unit

Overview:
- Synthesizable execution-trace and cycle-count unit for the 16-bit RISC pipeline.
- Counts clock cycles until halt and captures {cycle, IR, PC} records into an on-chip FIFO, with ready/valid readout.
- Sits beside risc_soc: taps IFU IR/PC and the halt flag, and exports trace records to a debug port or bench.
- Generalises the bench-only cycle counter and monitor with parametrised widths, depth and capture mode, plus overflow accounting.

Parameters:
- CC_W, 16: cycle counter width, 8..32.
- IR_W, 16: instruction register width.
- PC_W, 16: program counter width.
- DEPTH, 8: trace FIFO entries; must be a power of 2 and at least 2.
- DROP_W, 8: dropped-record counter width.

Ports:
- CLK  in  1  clock; rising edge only.
- RST_N  in  1  reset, asynchronous, active-low.
- CLEAR  in  1  synchronous clear of counters, FIFO and FSM.
- START  in  1  one-cycle pulse that begins a capture run.
- MODE  in  1  0 = record every cycle; 1 = record only when IR or PC changes.
- HOLT  in  1  processor halt flag.
- IR  in  IR_W  instruction register tap.
- PC  in  PC_W  program counter tap.
- CYCLE_COUNT  out  CC_W  cycles elapsed in RUN.
- HALTED  out  1  high in HALT state.
- TR_VALID  out  1  FIFO head valid.
- TR_READY  in  1  consumer accepts the head record.
- TR_DATA  out  CC_W+IR_W+PC_W  head record {cycle, IR, PC}, cycle in the MSBs.
- TR_FULL  out  1  FIFO full.
- DROP_COUNT  out  DROP_W  records lost to a full FIFO; saturates.

Behaviour:
- Reset (RST_N low, asynchronous): state IDLE; CYCLE_COUNT=0; HALTED=0; TR_VALID=0; TR_DATA=0; TR_FULL=0; DROP_COUNT=0; FIFO pointers 0; last-record register invalid.
- FSM states: IDLE, RUN, HALT.
  - IDLE -> RUN on START. The cycle of START itself is not counted.
  - RUN -> HALT on the first edge where HOLT=1.
  - HALT -> RUN on START. CYCLE_COUNT continues and is not zeroed.
  - Any state -> IDLE on CLEAR.
- CLEAR priority: CLEAR overrides START, HOLT and FIFO push/pop in the same cycle. It zeroes CYCLE_COUNT, DROP_COUNT and the FIFO, and invalidates the last-record register.
- Counter:
  - In RUN with HOLT=0: CYCLE_COUNT += 1 per rising edge; wraps modulo 2^CC_W.
  - Frozen in IDLE and HALT.
  - On the HOLT edge the counter holds, so the halt cycle is not counted.
- Capture, candidate record = {CYCLE_COUNT (pre-increment value), IR, PC}:
  - RUN, HOLT=0, MODE=0: push every cycle.
  - RUN, HOLT=0, MODE=1: push when IR or PC differs from the last pushed-or-dropped record, or when the last-record register is invalid. The first record after START or CLEAR is therefore always taken.
  - RUN, HOLT=1 (transition cycle): one final record is always pushed regardless of MODE, marking the halt point.
  - IDLE and HALT: no pushes.
- FIFO:
  - Storage DEPTH entries, pointers log2(DEPTH)+1 bits wide; wrap is implicit.
  - Full when pointers are equal except the MSB; empty when fully equal.
  - Pop occurs when TR_VALID && TR_READY. TR_DATA is the registered head, stable while TR_VALID && !TR_READY.
  - Push while full and no pop in the same cycle: record dropped, DROP_COUNT += 1, saturating at all-ones. The last-record register still updates.
  - Push and pop in the same cycle while full: both succeed; occupancy unchanged; no drop.
  - Push and pop in the same cycle while empty: the push is written and TR_VALID rises on the next cycle. No write-through, so latency from push to TR_VALID is 1 cycle.
- Readout continues in every state. The FIFO drains normally in HALT and IDLE.
- HALTED = (state == HALT), registered.
- No combinational path from inputs to outputs.

Decomposition:
- Package risc_trace_pkg:
  - trace_state_e enum {IDLE, RUN, HALT}.
  - Parametrised record packing/unpacking functions.
  - Constants MODE_ALL=0 and MODE_CHANGE=1.
- Sub-module risc_trace_fifo: generic synchronous FIFO with ready/valid output, full flag and push-dropped strobe. The top level holds the FSM, the counter, change detection and drop accounting.

Test Plan:
- Reset mid-RUN: START, 5 cycles, assert RST_N low -> all outputs zero immediately without waiting for a clock edge; FIFO empty.
- MODE=0, DEPTH=8, TR_READY=1, START, HOLT=1 after 6 counted cycles -> CYCLE_COUNT=6, HALTED=1, 7 records with cycles 0..5 plus a final record with cycle=6.
- MODE=1, IR constant 16'h1234, PC stepping 0,0,1,1,2 -> 3 change records plus 1 halt record; cycle fields 0, 2, 4, then the halt cycle.
- Overflow: MODE=0, TR_READY=0, DEPTH=8, run 20 cycles -> TR_FULL=1, DROP_COUNT=12; then READY=1 pops records with cycles 0..7 in order.
- Full plus simultaneous push/pop: FIFO full, READY=1 for 3 RUN cycles -> DROP_COUNT unchanged, TR_FULL stays 1.
- CLEAR in the same cycle as START and HOLT, with CC_W=8 wrap test (255 -> 0 in RUN): CLEAR wins, state IDLE, counters 0; the wrap test counts 255 then 0 with no error.
